// File: rtl/clk_iq_mon.sv
// -----------------------------------------------------------------------------
// clk_iq_mon
//   Lock/health monitor for the /2 I/Q clock divider. The 4-phase bus
//   {~Q,~I,Q,I} is sampled on every rising edge of the full-rate clock and
//   checked for complement, quadrature and toggle integrity. An acquire/lock
//   state machine tracks link health, per-sample errors are reported as
//   single-cycle pulses, and a saturating error count is kept for firmware.
//
// Parameters
//   SYNC_STAGES : flops on iq_in ahead of the sample register (0..3)
//   LOCK_CNT    : consecutive good samples needed to declare lock (2..255)
//   ERR_TOL     : consecutive bad samples in LOCKED that drop lock (1..15)
//   ERR_W       : width of err_cnt (saturates at all-ones)
//
// Ports
//   cki       in   full-rate clock (same clock that drives the divider)
//   rstn      in   asynchronous active-low reset
//   en        in   monitor enable; 0 freezes FSM/counters, no errors flagged
//   clr       in   synchronous clear of err_cnt and lost_lock
//   iq_in     in   [0]=I [1]=Q [2]=~I [3]=~Q
//   lock      out  1 while the FSM is in LOCKED
//   err       out  1-cycle pulse per bad checked sample
//   err_code  out  {toggle, quadrature, complement} failure flags, valid with err
//   err_cnt   out  saturating count of bad samples
//   lost_lock out  sticky, set on LOCKED->ACQ, cleared by clr
// -----------------------------------------------------------------------------
module clk_iq_mon #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 16,
  parameter int ERR_TOL     = 3,
  parameter int ERR_W       = 8
) (
  input  logic             cki,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [3:0]       iq_in,
  output logic             lock,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [ERR_W-1:0] err_cnt,
  output logic             lost_lock
);

  typedef enum logic {
    ACQ    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] synced;
  logic [3:0] s;
  logic       prev_i;
  logic       hist_vld;
  logic [7:0] good_cnt;
  logic [3:0] bad_cnt;
  logic       c0, c1, c2;
  logic       bad, good;
  logic       lock_loss;

  // ---------------------------------------------------------------------------
  // Synchronizer pipe; keeps running regardless of en.
  // ---------------------------------------------------------------------------
  if (SYNC_STAGES == 0) begin : g_no_sync
    assign synced = iq_in;
  end else begin : g_sync
    logic [3:0] sync_q [SYNC_STAGES];

    // NOTE: this small flop array is reset element by element; it is a
    // register chain, not a RAM, so a reset costs nothing and keeps the
    // first checked samples deterministic.
    always_ff @(posedge cki or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= iq_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign synced = sync_q[SYNC_STAGES-1];
  end

  // NOTE: every sequential process uses non-blocking assignments so all
  // flops see pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge cki or negedge rstn) begin
    if (!rstn) s <= '0;
    else       s <= synced;
  end

  // Toggle history: prev_i follows every enabled sample, good or bad.
  // hist_vld drops whenever the monitor is disabled so the first sample
  // after re-enable skips the toggle check.
  always_ff @(posedge cki or negedge rstn) begin
    if (!rstn) begin
      prev_i   <= 1'b0;
      hist_vld <= 1'b0;
    end else if (en) begin
      prev_i   <= s[0];
      hist_vld <= 1'b1;
    end else begin
      hist_vld <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample checks
  // ---------------------------------------------------------------------------
  always_comb begin
    // Inverted lines must be the exact complement of the true lines.
    c0   = (s[2] == s[0]) || (s[3] == s[1]);
    // At cki rise Q has caught up with I, so I and Q must agree.
    c1   = (s[0] != s[1]);
    // I must change on every full-rate edge.
    c2   = hist_vld && (s[0] == prev_i);
    bad  = en && (c0 || c1 || c2);
    good = en && !(c0 || c1 || c2);
  end

  always_ff @(posedge cki or negedge rstn) begin
    if (!rstn) begin
      err      <= 1'b0;
      err_code <= '0;
    end else begin
      err      <= bad;
      err_code <= bad ? {c2, c1, c0} : 3'b000;
    end
  end

  // ---------------------------------------------------------------------------
  // Acquire/lock FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge cki or negedge rstn) begin
    if (!rstn) state_q <= ACQ;
    else       state_q <= state_d;
  end

  // NOTE: next state defaults to the current state before the case so no
  // path leaves state_d unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACQ: begin
        if (good && (good_cnt == 8'(LOCK_CNT - 1))) state_d = LOCKED;
      end
      LOCKED: begin
        if (bad && (bad_cnt == 4'(ERR_TOL - 1))) state_d = ACQ;
      end
      default: state_d = ACQ;
    endcase
  end

  always_comb begin
    lock      = (state_q == LOCKED);
    lock_loss = (state_q == LOCKED) && (state_d == ACQ);
  end

  // Run-length counters; both hold while en=0 (good and bad are both 0 then).
  always_ff @(posedge cki or negedge rstn) begin
    if (!rstn) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (en) begin
      if (state_q == ACQ) begin
        bad_cnt <= '0;
        if (bad || state_d == LOCKED) good_cnt <= '0;
        else                          good_cnt <= good_cnt + 8'd1;
      end else begin
        good_cnt <= '0;
        if (good || lock_loss) bad_cnt <= '0;
        else                   bad_cnt <= bad_cnt + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error count and sticky lock-loss flag
  // ---------------------------------------------------------------------------
  // clr beats a concurrent bad sample for the count.
  always_ff @(posedge cki or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (bad && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  // A concurrent lock loss beats clr so the event is never missed.
  always_ff @(posedge cki or negedge rstn) begin
    if (!rstn)          lost_lock <= 1'b0;
    else if (lock_loss) lost_lock <= 1'b1;
    else if (clr)       lost_lock <= 1'b0;
  end

endmodule

// File: tb/tb_clk_iq_mon.sv
// -----------------------------------------------------------------------------
// tb_clk_iq_mon
//   Directed bench for clk_iq_mon (SYNC_STAGES=2, LOCK_CNT=16, ERR_TOL=3,
//   ERR_W=8). Stimulus is driven 1 time unit after each rising edge and
//   outputs are sampled at the same point. A light monitor accumulates err
//   pulses, OR of err codes and whether lock was ever seen.
// -----------------------------------------------------------------------------
module tb_clk_iq_mon;

  logic       cki   = 1'b0;
  logic       rstn  = 1'b0;
  logic       en    = 1'b0;
  logic       clr   = 1'b0;
  logic [3:0] iq_in = 4'b1100;
  logic       lock;
  logic       err;
  logic [2:0] err_code;
  logic [7:0] err_cnt;
  logic       lost_lock;

  int         n_checks = 0;
  int         n_errors = 0;
  int         err_pulses = 0;
  logic [2:0] code_or = '0;
  logic       lock_seen = 1'b0;
  logic       ph = 1'b0;   // I value of the last ideal vector driven
  logic       sw = 1'b0;   // phase of the swapped-line pattern

  clk_iq_mon #(
    .SYNC_STAGES(2),
    .LOCK_CNT   (16),
    .ERR_TOL    (3),
    .ERR_W      (8)
  ) dut (
    .cki      (cki),
    .rstn     (rstn),
    .en       (en),
    .clr      (clr),
    .iq_in    (iq_in),
    .lock     (lock),
    .err      (err),
    .err_code (err_code),
    .err_cnt  (err_cnt),
    .lost_lock(lost_lock)
  );

  always #5 cki = ~cki;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cki);
    #1;
    if (err) begin
      err_pulses++;
      code_or |= err_code;
    end
    if (lock) lock_seen = 1'b1;
  endtask

  task automatic step(input logic [3:0] v, input logic c);
    iq_in = v;
    clr   = c;
    tick();
    clr   = 1'b0;
  endtask

  task automatic step_ideal(input logic c);
    ph = ~ph;
    step(ph ? 4'b0011 : 4'b1100, c);
  endtask

  // Ideal toggle with ~I shorted to I: complement failure only.
  task automatic step_c0();
    logic [3:0] v;
    ph = ~ph;
    v = ph ? 4'b0011 : 4'b1100;
    v[2] = v[0];
    step(v, 1'b0);
  endtask

  // I and Q swapped: I toggles, complements intact, but I != Q every sample.
  task automatic step_swapped();
    sw = ~sw;
    step(sw ? 4'b1001 : 4'b0110, 1'b0);
  endtask

  // Leave ph=0 so a following static 1100 fails the toggle check at once.
  task automatic align_low();
    if (ph) step_ideal(1'b0);
  endtask

  task automatic clear_mon();
    err_pulses = 0;
    code_or    = '0;
    lock_seen  = 1'b0;
  endtask

  initial begin
    // ---------------- reset values
    repeat (3) @(posedge cki);
    #1;
    check("rst_lock", lock, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_lost_lock", lost_lock, 0);
    rstn = 1'b1;

    // ---------------- T1: ideal divider, lock on 16th good enabled sample
    clear_mon();
    repeat (6) step_ideal(1'b0);
    en = 1'b1;
    repeat (15) step_ideal(1'b0);
    check("t1_no_lock_after_15", lock, 0);
    step_ideal(1'b0);
    check("t1_lock_after_16", lock, 1);
    check("t1_no_err_pulses", err_pulses, 0);
    check("t1_err_cnt", err_cnt, 0);

    // ---------------- T2: single complement glitch, latency 4 edges
    clear_mon();
    step_c0();
    step_ideal(1'b0);
    step_ideal(1'b0);
    check("t2_err_not_early", err, 0);
    step_ideal(1'b0);
    check("t2_err_pulse", err, 1);
    check("t2_err_code", err_code, 3'b001);
    check("t2_err_cnt", err_cnt, 1);
    check("t2_lock_held", lock, 1);
    repeat (4) step_ideal(1'b0);
    check("t2_single_pulse", err_pulses, 1);
    check("t2_lock_still", lock, 1);

    // ---------------- T3: frozen divider for 3 samples -> lock loss, relock
    align_low();
    clear_mon();
    repeat (3) step(4'b1100, 1'b0);
    step_ideal(1'b0);
    step_ideal(1'b0);
    check("t3_lock_after_2_bad", lock, 1);
    step_ideal(1'b0);
    check("t3_lock_dropped", lock, 0);
    check("t3_lost_lock", lost_lock, 1);
    check("t3_err_code", err_code, 3'b100);
    check("t3_err_cnt", err_cnt, 4);
    check("t3_pulses", err_pulses, 3);
    check("t3_code_or", code_or, 3'b100);
    repeat (15) step_ideal(1'b0);
    check("t3_no_relock_15", lock, 0);
    step_ideal(1'b0);
    check("t3_relock_16", lock, 1);

    // ---------------- T5a: clr together with a bad sample, no lock loss
    clear_mon();
    step_c0();
    step_ideal(1'b0);
    step_ideal(1'b0);
    step_ideal(1'b1);
    check("t5a_err_pulse", err, 1);
    check("t5a_err_cnt_cleared", err_cnt, 0);
    check("t5a_lost_lock_cleared", lost_lock, 0);
    check("t5a_lock_held", lock, 1);

    // ---------------- T5b: clr together with the lock-losing sample
    align_low();
    clear_mon();
    repeat (3) step(4'b1100, 1'b0);
    step_ideal(1'b0);
    step_ideal(1'b0);
    step_ideal(1'b1);
    check("t5b_err_cnt_cleared", err_cnt, 0);
    check("t5b_lost_lock_set_wins", lost_lock, 1);
    check("t5b_lock_dropped", lock, 0);
    check("t5b_pulses", err_pulses, 3);
    repeat (16) step_ideal(1'b0);
    check("t5b_relock", lock, 1);

    // ---------------- build err_cnt=5 while locked
    clear_mon();
    repeat (5) begin
      step_c0();
      repeat (5) step_ideal(1'b0);
    end
    check("pre6_err_cnt", err_cnt, 5);
    check("pre6_pulses", err_pulses, 5);
    check("pre6_lock", lock, 1);

    // ---------------- T6b: en=0 with bad input, nothing moves
    clear_mon();
    en = 1'b0;
    repeat (10) step(4'b1100, 1'b0);
    repeat (6) step_ideal(1'b0);
    en = 1'b1;
    repeat (4) step_ideal(1'b0);
    check("t6_en0_no_err", err_pulses, 0);
    check("t6_en0_err_cnt_held", err_cnt, 5);
    check("t6_en0_lock_held", lock, 1);

    // ---------------- T6: asynchronous reset mid-cycle while locked
    #2;
    rstn = 1'b0;
    #1;
    check("t6_async_lock", lock, 0);
    check("t6_async_err_cnt", err_cnt, 0);
    check("t6_async_lost_lock", lost_lock, 0);
    @(negedge cki);
    @(negedge cki);
    rstn = 1'b1;

    // ---------------- T4: I/Q swapped, never locks, err_cnt saturates
    en = 1'b0;
    clear_mon();
    repeat (6) step_swapped();
    en = 1'b1;
    repeat (254) step_swapped();
    check("t4_err_cnt_254", err_cnt, 254);
    step_swapped();
    check("t4_err_cnt_255", err_cnt, 255);
    repeat (45) step_swapped();
    check("t4_err_cnt_saturated", err_cnt, 255);
    check("t4_err_code", err_code, 3'b010);
    check("t4_code_or", code_or, 3'b010);
    check("t4_never_locked", lock_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
